galvo_scan_gen: RTL and testbench
=================================

Name: galvo_scan_gen

Overview:
- Raster scan generator directly upstream of the CCD trigger generator in the OCT slave driver.
- Produces per-point galvo X/Y DAC codes at a programmable point period, and strobes the DAC interface on each update.
- Issues the one-cycle data_rdy pulse that starts the CCD trigger generator, using the same point timing (cycles_per_points) so both stay aligned.

Parameters:
- DAC_W, 16, width of the X/Y DAC codes and of the start/step values.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  begin scan; sampled in IDLE only
- abort  in  1  synchronous scan abort
- x_start  in  DAC_W  first X code of each line
- x_step  in  DAC_W  X increment per point (mod 2^DAC_W)
- y_start  in  DAC_W  Y code of the first line
- y_step  in  DAC_W  Y increment per line (mod 2^DAC_W)
- xdata_points_number  in  16  points per line
- ydata_points_number  in  16  lines per frame
- cycles_per_points  in  16  point period minus 1
- x_code  out  DAC_W  current X DAC code
- y_code  out  DAC_W  current Y DAC code
- dac_load  out  1  one-cycle strobe; new x_code/y_code valid
- data_rdy  out  1  one-cycle pulse at first point of the frame
- line_sync  out  1  one-cycle pulse at the first point of lines 1..yn-1
- busy  out  1  high during a scan
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- FSM states:
  - IDLE: wait for start.
  - SCAN: step through points.
  - IDLE is also the terminal state; there is no separate end state.
- Start handling:
  - In IDLE, start=1 latches all config inputs into shadow registers.
  - Config inputs are don't-care until the next start.
  - start is ignored while busy=1.
- Zero-size scan: if xn==0 or yn==0 at start, done pulses the next cycle and the FSM stays in IDLE. No data_rdy, no dac_load, busy stays 0.
- Scan entry: on the cycle after an accepted start:
  - state=SCAN, busy=1;
  - x_code=x_start, y_code=y_start;
  - dac_load=1 and data_rdy=1 (both one cycle).
- Point counter pc runs 0..cycles_per_points. A point lasts P=cycles_per_points+1 cycles. cycles_per_points=0 gives one point per cycle.
- When pc==cycles_per_points: pc<=0, and the next action is:
  - if xi<xn-1: xi+1, x_code+=x_step, dac_load=1;
  - else if yi<yn-1: xi<=0, x_code<=x_start, yi+1, y_code+=y_step, dac_load=1, line_sync=1;
  - else: IDLE, busy<=0, done=1 for one cycle; x_code/y_code hold their last values.
- Code arithmetic is modulo 2^DAC_W; wrap-around is silent.
- abort=1 in SCAN: next cycle IDLE, busy=0, counters cleared, no done, codes hold. abort in IDLE has no effect.
- Simultaneous events:
  - abort beats point advance;
  - start concurrent with the done cycle is ignored (busy deasserts the same cycle done pulses, so start is accepted from the following cycle).
- Reset mid-scan: immediate return to reset values; no done.
- Counters xi, yi and pc are 16-bit; the full 16-bit range of xn and yn is supported.

Test Plan:
- Basic raster: xn=3, yn=2, cpp=1, x_start=100, x_step=10, y_start=500, y_step=20, start at cycle 0.
  - data_rdy at cycle 1.
  - dac_load at cycles 1,3,5,7,9,11 with (x,y) = (100,500), (110,500), (120,500), (100,520), (110,520), (120,520).
  - line_sync at cycle 7 only; done at cycle 13; busy high for cycles 1-12.
- Zero dims: xn=0, yn=5, start -> done one cycle later; no dac_load, no data_rdy, busy never high.
- Wrap: x_start=16'hFFF0, x_step=16'h0010, xn=2, yn=1, cpp=0 -> x_code 16'hFFF0 then 16'h0000; done at cycle 3.
- Abort: xn=4, yn=4, cpp=3, abort at cycle 10 -> busy low at cycle 11; no done; a subsequent start runs the full frame from x_start/y_start.
- Start while busy: a second start mid-scan, with changed config, has no effect on codes or timing; the first frame completes unchanged.
- Reset mid-scan: rstn low during a scan -> all outputs 0 asynchronously; after release, IDLE and a new start works normally.

Source files
------------

// File: rtl/galvo_scan_gen_if.sv
// Control, configuration and DAC-side signals of the galvo raster scan generator.
// master drives start/abort/config and observes codes/strobes; slave is the generator.
interface galvo_scan_gen_if #(
  parameter int unsigned DAC_W = 16
);
  localparam int unsigned CNT_W = 16;

  logic             start;
  logic             abort;
  logic [DAC_W-1:0] x_start;
  logic [DAC_W-1:0] x_step;
  logic [DAC_W-1:0] y_start;
  logic [DAC_W-1:0] y_step;
  logic [CNT_W-1:0] xdata_points_number;
  logic [CNT_W-1:0] ydata_points_number;
  logic [CNT_W-1:0] cycles_per_points;
  logic [DAC_W-1:0] x_code;
  logic [DAC_W-1:0] y_code;
  logic             dac_load;
  logic             data_rdy;
  logic             line_sync;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, x_start, x_step, y_start, y_step,
           xdata_points_number, ydata_points_number, cycles_per_points,
    input  x_code, y_code, dac_load, data_rdy, line_sync, busy, done
  );

  modport slave (
    input  start, abort, x_start, x_step, y_start, y_step,
           xdata_points_number, ydata_points_number, cycles_per_points,
    output x_code, y_code, dac_load, data_rdy, line_sync, busy, done
  );
endinterface

// File: rtl/galvo_scan_gen.sv
// Raster scan generator: steps galvo X/Y DAC codes at a programmable point period
// and emits the frame-start pulse (data_rdy) that kicks the CCD trigger generator.
module galvo_scan_gen #(
  parameter int unsigned DAC_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  galvo_scan_gen_if.slave   bus
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_e;

  state_e           state_q,     state_d;
  logic [DAC_W-1:0] x_start_q,   x_start_d;
  logic [DAC_W-1:0] x_step_q,    x_step_d;
  logic [DAC_W-1:0] y_step_q,    y_step_d;
  logic [CNT_W-1:0] xn_q,        xn_d;
  logic [CNT_W-1:0] yn_q,        yn_d;
  logic [CNT_W-1:0] cpp_q,       cpp_d;
  logic [CNT_W-1:0] pc_q,        pc_d;
  logic [CNT_W-1:0] xi_q,        xi_d;
  logic [CNT_W-1:0] yi_q,        yi_d;
  logic [DAC_W-1:0] x_code_q,    x_code_d;
  logic [DAC_W-1:0] y_code_q,    y_code_d;
  logic             dac_load_q,  dac_load_d;
  logic             data_rdy_q,  data_rdy_d;
  logic             line_sync_q, line_sync_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    x_start_d   = x_start_q;
    x_step_d    = x_step_q;
    y_step_d    = y_step_q;
    xn_d        = xn_q;
    yn_d        = yn_q;
    cpp_d       = cpp_q;
    pc_d        = pc_q;
    xi_d        = xi_q;
    yi_d        = yi_q;
    x_code_d    = x_code_q;
    y_code_d    = y_code_q;
    busy_d      = busy_q;
    dac_load_d  = 1'b0;
    data_rdy_d  = 1'b0;
    line_sync_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse belongs to the finished frame.
        if (bus.start && !done_q) begin
          if ((bus.xdata_points_number == CNT_W'(0)) ||
              (bus.ydata_points_number == CNT_W'(0))) begin
            done_d = 1'b1;
          end else begin
            state_d    = SCAN;
            busy_d     = 1'b1;
            x_start_d  = bus.x_start;
            x_step_d   = bus.x_step;
            y_step_d   = bus.y_step;
            xn_d       = bus.xdata_points_number;
            yn_d       = bus.ydata_points_number;
            cpp_d      = bus.cycles_per_points;
            pc_d       = CNT_W'(0);
            xi_d       = CNT_W'(0);
            yi_d       = CNT_W'(0);
            x_code_d   = bus.x_start;
            y_code_d   = bus.y_start;
            dac_load_d = 1'b1;
            data_rdy_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          pc_d    = CNT_W'(0);
          xi_d    = CNT_W'(0);
          yi_d    = CNT_W'(0);
        end else if (pc_q == cpp_q) begin
          pc_d = CNT_W'(0);
          if (xi_q != xn_q - CNT_W'(1)) begin
            xi_d       = xi_q + CNT_W'(1);
            x_code_d   = x_code_q + x_step_q;
            dac_load_d = 1'b1;
          end else if (yi_q != yn_q - CNT_W'(1)) begin
            xi_d        = CNT_W'(0);
            x_code_d    = x_start_q;
            yi_d        = yi_q + CNT_W'(1);
            y_code_d    = y_code_q + y_step_q;
            dac_load_d  = 1'b1;
            line_sync_d = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            xi_d    = CNT_W'(0);
            yi_d    = CNT_W'(0);
          end
        end else begin
          pc_d = pc_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      x_start_q   <= '0;
      x_step_q    <= '0;
      y_step_q    <= '0;
      xn_q        <= '0;
      yn_q        <= '0;
      cpp_q       <= '0;
      pc_q        <= '0;
      xi_q        <= '0;
      yi_q        <= '0;
      x_code_q    <= '0;
      y_code_q    <= '0;
      dac_load_q  <= 1'b0;
      data_rdy_q  <= 1'b0;
      line_sync_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_start_q   <= x_start_d;
      x_step_q    <= x_step_d;
      y_step_q    <= y_step_d;
      xn_q        <= xn_d;
      yn_q        <= yn_d;
      cpp_q       <= cpp_d;
      pc_q        <= pc_d;
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      x_code_q    <= x_code_d;
      y_code_q    <= y_code_d;
      dac_load_q  <= dac_load_d;
      data_rdy_q  <= data_rdy_d;
      line_sync_q <= line_sync_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.x_code    = x_code_q;
  assign bus.y_code    = y_code_q;
  assign bus.dac_load  = dac_load_q;
  assign bus.data_rdy  = data_rdy_q;
  assign bus.line_sync = line_sync_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_galvo_scan_gen.sv
// Directed bench for galvo_scan_gen: raster order, zero dims, wrap, abort,
// start-while-busy and asynchronous reset mid-scan.
module tb_galvo_scan_gen;
  localparam int unsigned DAC_W = 16;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  galvo_scan_gen_if #(.DAC_W(DAC_W)) bus ();

  galvo_scan_gen #(.DAC_W(DAC_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start is present in cycle 0 and sampled at the following edge; returns in cycle 1.
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] xs, input logic [15:0] xst, input logic [15:0] ys,
                     input logic [15:0] yst, input logic [15:0] xn, input logic [15:0] yn,
                     input logic [15:0] cpp);
    bus.x_start = xs;  bus.x_step = xst;
    bus.y_start = ys;  bus.y_step = yst;
    bus.xdata_points_number = xn;
    bus.ydata_points_number = yn;
    bus.cycles_per_points   = cpp;
  endtask

  // Basic 3x2 raster, cpp=1; optionally a second start with new config mid-scan.
  task automatic run_basic(input string pfx, input bit inject);
    logic [13:0] load_exp = 14'h0AAA;
    logic [13:0] rdy_exp  = 14'h0002;
    logic [13:0] ls_exp   = 14'h0080;
    logic [13:0] busy_exp = 14'h1FFE;
    logic [13:0] done_exp = 14'h2000;
    logic [15:0] xe [6] = '{16'd100, 16'd110, 16'd120, 16'd100, 16'd110, 16'd120};
    logic [15:0] ye [6] = '{16'd500, 16'd500, 16'd500, 16'd520, 16'd520, 16'd520};
    int k = 0;
    cfg(16'd100, 16'd10, 16'd500, 16'd20, 16'd3, 16'd2, 16'd1);
    pulse_start();
    for (int c = 1; c <= 13; c++) begin
      chk($sformatf("%s dac_load c%0d", pfx, c), 32'(bus.dac_load), 32'(load_exp[c]));
      chk($sformatf("%s data_rdy c%0d", pfx, c), 32'(bus.data_rdy), 32'(rdy_exp[c]));
      chk($sformatf("%s line_sync c%0d", pfx, c), 32'(bus.line_sync), 32'(ls_exp[c]));
      chk($sformatf("%s busy c%0d", pfx, c), 32'(bus.busy), 32'(busy_exp[c]));
      chk($sformatf("%s done c%0d", pfx, c), 32'(bus.done), 32'(done_exp[c]));
      if (load_exp[c] && k < 6) begin
        chk($sformatf("%s x_code pt%0d", pfx, k), 32'(bus.x_code), 32'(xe[k]));
        chk($sformatf("%s y_code pt%0d", pfx, k), 32'(bus.y_code), 32'(ye[k]));
        k++;
      end
      if (inject && c == 5) begin
        cfg(16'd7, 16'd3, 16'd9, 16'd4, 16'd9, 16'd9, 16'd0);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (c != 13) tick();
    end
    chk({pfx, " x_code hold"}, 32'(bus.x_code), 32'd120);
    chk({pfx, " y_code hold"}, 32'(bus.y_code), 32'd520);
    tick();
    chk({pfx, " done single"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int loads;
    int dones;
    int syncs;
    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cfg(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset x_code", 32'(bus.x_code), 32'd0);
    chk("reset y_code", 32'(bus.y_code), 32'd0);
    chk("reset outs", {27'd0, bus.dac_load, bus.data_rdy, bus.line_sync, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    run_basic("basic", 1'b0);
    run_basic("busy_start", 1'b1);
    tick();

    // Zero-size scan
    cfg(16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd5, 16'd2);
    pulse_start();
    chk("zero done", 32'(bus.done), 32'd1);
    chk("zero strobes", {29'd0, bus.dac_load, bus.data_rdy, bus.busy}, 32'd0);
    tick();
    chk("zero after", {29'd0, bus.done, bus.dac_load, bus.busy}, 32'd0);
    tick();

    // Wrap-around, one point per cycle
    cfg(16'hFFF0, 16'h0010, 16'h1234, 16'h0001, 16'd2, 16'd1, 16'd0);
    pulse_start();
    chk("wrap c1 x", 32'(bus.x_code), 32'h0000FFF0);
    chk("wrap c1 y", 32'(bus.y_code), 32'h00001234);
    chk("wrap c1 load/rdy", {30'd0, bus.dac_load, bus.data_rdy}, 32'd3);
    tick();
    chk("wrap c2 x", 32'(bus.x_code), 32'h00000000);
    chk("wrap c2 load/busy", {30'd0, bus.dac_load, bus.busy}, 32'd3);
    chk("wrap c2 line_sync", 32'(bus.line_sync), 32'd0);
    tick();
    chk("wrap c3 done/busy", {30'd0, bus.done, bus.busy}, 32'd2);
    tick();

    // Abort in point 2 of line 0
    cfg(16'd1000, 16'd5, 16'd2000, 16'd7, 16'd4, 16'd4, 16'd3);
    pulse_start();
    repeat (9) tick();
    chk("abort c10 busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort c11 busy", 32'(bus.busy), 32'd0);
    chk("abort c11 done", 32'(bus.done), 32'd0);
    chk("abort x hold", 32'(bus.x_code), 32'd1010);
    chk("abort y hold", 32'(bus.y_code), 32'd2000);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      dones += int'(bus.done) + int'(bus.busy);
    end
    chk("abort quiet", 32'(dones), 32'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort idle noop", {30'd0, bus.busy, bus.done}, 32'd0);

    // Full 4x4 frame after abort: 16 points x 4 cycles, done at cycle 65
    cfg(16'd1000, 16'd5, 16'd2000, 16'd7, 16'd4, 16'd4, 16'd3);
    pulse_start();
    chk("rerun x start", 32'(bus.x_code), 32'd1000);
    chk("rerun y start", 32'(bus.y_code), 32'd2000);
    chk("rerun data_rdy", 32'(bus.data_rdy), 32'd1);
    loads = 0; dones = 0; syncs = 0;
    for (int c = 1; c <= 65; c++) begin
      loads += int'(bus.dac_load);
      dones += int'(bus.done);
      syncs += int'(bus.line_sync);
      if (c == 64) chk("rerun busy c64", 32'(bus.busy), 32'd1);
      if (c != 65) tick();
    end
    chk("rerun done c65", 32'(bus.done), 32'd1);
    chk("rerun busy c65", 32'(bus.busy), 32'd0);
    chk("rerun loads", 32'(loads), 32'd16);
    chk("rerun dones", 32'(dones), 32'd1);
    chk("rerun line_syncs", 32'(syncs), 32'd3);
    chk("rerun x final", 32'(bus.x_code), 32'd1015);
    chk("rerun y final", 32'(bus.y_code), 32'd2021);
    tick();

    // Asynchronous reset mid-scan
    cfg(16'd100, 16'd10, 16'd500, 16'd20, 16'd3, 16'd2, 16'd1);
    pulse_start();
    repeat (3) tick();
    chk("rst pre busy", 32'(bus.busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst async x", 32'(bus.x_code), 32'd0);
    chk("rst async y", 32'(bus.y_code), 32'd0);
    chk("rst async outs", {27'd0, bus.dac_load, bus.data_rdy, bus.line_sync, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      dones += int'(bus.done) + int'(bus.busy) + int'(bus.dac_load);
    end
    chk("rst no activity", 32'(dones), 32'd0);
    cfg(16'hFFF0, 16'h0010, 16'h0042, 16'h0001, 16'd2, 16'd1, 16'd0);
    pulse_start();
    chk("rst restart x", 32'(bus.x_code), 32'h0000FFF0);
    chk("rst restart y", 32'(bus.y_code), 32'h00000042);
    chk("rst restart rdy", 32'(bus.data_rdy), 32'd1);
    repeat (2) tick();
    chk("rst restart done", 32'(bus.done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
